// File: rtl/fft_host_ctrl.sv
// Host-side sequencer for the in-place FFT core.
// It streams one frame of samples into the core and pulses start.
// It then waits for completion, or for a timeout.
// Finally it reads the results back onto an output stream through a 2-entry skid buffer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_LOAD  | accept samples, write them to core addresses 0..N-1
// ST_START | last write on the bus; pulse fft_sig next
// ST_WAIT  | wait for fft_done or timer terminal count (sets sticky err)
// ST_READ  | issue reads 0..N-1, drain results, exit on m_last handshake
module fft_host_ctrl #(
   parameter int LOGN     = 12,
   parameter int CW       = 64,
   parameter bit REV_READ = 1'b1,
   parameter int TIMEOUT  = 65535
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            s_valid_i,
   output logic            s_ready_o,
   input  logic [CW-1:0]   s_data_i,
   output logic            m_valid_o,
   input  logic            m_ready_i,
   output logic [CW-1:0]   m_data_o,
   output logic            m_last_o,
   output logic            fft_sig_o,
   output logic            fft_we_o,
   output logic            fft_rev_o,
   output logic [LOGN-1:0] fft_addr_o,
   output logic [CW-1:0]   fft_din_o,
   input  logic [CW-1:0]   fft_dout_i,
   input  logic            fft_done_i,
   output logic            busy_o,
   output logic            err_o
);

   typedef enum logic [1:0] {ST_LOAD, ST_START, ST_WAIT, ST_READ} state_t;

   localparam logic [LOGN-1:0] ADDR_LAST = '1;
   localparam logic [15:0]     TMO_LAST  = 16'(TIMEOUT - 1);

   state_t          state_q;
   logic [LOGN-1:0] wcnt_q;
   logic [15:0]     timer_q;
   logic            s_ready_q;
   logic            fft_sig_q;
   logic            fft_we_q;
   logic            fft_rev_q;
   logic [LOGN-1:0] fft_addr_q;
   logic [CW-1:0]   fft_din_q;
   logic            err_q;

   // fft_addr_q doubles as the read pointer; rd_pend_q marks the read whose data is on fft_dout
   logic            rd_pend_q;
   logic            rd_pend_last_q;
   logic            rd_all_q;

   logic [CW-1:0]   buf_data_q [2];
   logic            buf_last_q [2];
   logic            buf_wr_q;
   logic            buf_rd_q;
   logic [1:0]      buf_cnt_q;

   logic            s_accept;
   logic            m_pop;
   logic            rd_issue;
   logic [2:0]      rd_need;
   logic [2:0]      rd_limit;

   assign s_accept  = s_valid_i && s_ready_q;
   assign m_valid_o = (buf_cnt_q != 2'd0);
   assign m_data_o  = buf_data_q[buf_rd_q];
   assign m_last_o  = m_valid_o && buf_last_q[buf_rd_q];
   assign m_pop     = m_valid_o && m_ready_i;

   // Issue a read only if the buffer can still hold it after the pending capture,
   // counting a pop this cycle as a freed slot so a streaming sink sees 1 word/clk.
   always_comb begin
      rd_need  = {1'b0, buf_cnt_q} + {2'b00, rd_pend_q};
      rd_limit = 3'd2 + {2'b00, m_pop};
      rd_issue = (state_q == ST_READ) && !rd_all_q && (rd_need < rd_limit);
   end

   // Sequencer and all registered core-side outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ST_LOAD;
         wcnt_q         <= '0;
         timer_q        <= '0;
         s_ready_q      <= 1'b1;
         fft_sig_q      <= 1'b0;
         fft_we_q       <= 1'b0;
         fft_rev_q      <= 1'b0;
         fft_addr_q     <= '0;
         fft_din_q      <= '0;
         err_q          <= 1'b0;
         rd_pend_q      <= 1'b0;
         rd_pend_last_q <= 1'b0;
         rd_all_q       <= 1'b0;
      end else begin
         fft_we_q  <= 1'b0;
         fft_sig_q <= 1'b0;
         rd_pend_q <= 1'b0;
         unique case (state_q)
            ST_LOAD: begin
               if (s_accept) begin
                  fft_we_q   <= 1'b1;
                  fft_addr_q <= wcnt_q;
                  fft_din_q  <= s_data_i;
                  wcnt_q     <= wcnt_q + 1'b1;
                  if (wcnt_q == ADDR_LAST) begin
                     s_ready_q <= 1'b0;
                     state_q   <= ST_START;
                  end
               end
            end
            ST_START: begin
               fft_sig_q <= 1'b1;
               timer_q   <= '0;
               state_q   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (fft_done_i || (timer_q == TMO_LAST)) begin
                  if (!fft_done_i) begin
                     err_q <= 1'b1;
                  end
                  state_q    <= ST_READ;
                  fft_rev_q  <= REV_READ;
                  fft_addr_q <= '0;
                  rd_all_q   <= 1'b0;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            ST_READ: begin
               if (rd_issue) begin
                  rd_pend_q      <= 1'b1;
                  rd_pend_last_q <= (fft_addr_q == ADDR_LAST);
                  fft_addr_q     <= fft_addr_q + 1'b1;
                  if (fft_addr_q == ADDR_LAST) begin
                     rd_all_q <= 1'b1;
                  end
               end
               if (m_pop && m_last_o) begin
                  state_q   <= ST_LOAD;
                  s_ready_q <= 1'b1;
                  fft_rev_q <= 1'b0;
                  rd_all_q  <= 1'b0;
               end
            end
            default: state_q <= ST_LOAD;
         endcase
      end
   end

   // Two-entry result buffer: capture core data one cycle after issue, drain on handshake
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         buf_data_q <= '{default: '0};
         buf_last_q <= '{default: 1'b0};
         buf_wr_q   <= 1'b0;
         buf_rd_q   <= 1'b0;
         buf_cnt_q  <= 2'd0;
      end else begin
         if (rd_pend_q) begin
            buf_data_q[buf_wr_q] <= fft_dout_i;
            buf_last_q[buf_wr_q] <= rd_pend_last_q;
            buf_wr_q             <= ~buf_wr_q;
         end
         if (m_pop) begin
            buf_rd_q <= ~buf_rd_q;
         end
         buf_cnt_q <= buf_cnt_q + {1'b0, rd_pend_q} - {1'b0, m_pop};
      end
   end

   assign s_ready_o  = s_ready_q;
   assign fft_sig_o  = fft_sig_q;
   assign fft_we_o   = fft_we_q;
   assign fft_rev_o  = fft_rev_q;
   assign fft_addr_o = fft_addr_q;
   assign fft_din_o  = fft_din_q;
   assign err_o      = err_q;
   assign busy_o     = !((state_q == ST_LOAD) && (wcnt_q == '0));

endmodule
